// File: rtl/constraint_sample_gen_if.sv
// Solution output bus of constraint_sample_gen: a valid/ready stream that
// carries each satisfying candidate vector to the downstream consumer.
interface constraint_sample_gen_if #(
  parameter int VEC_W = 64
);
  logic             sol_valid;
  logic             sol_ready;
  logic [VEC_W-1:0] sol_data;

  // The sampler drives the stream and the consumer answers with ready.
  modport master (output sol_valid, output sol_data, input sol_ready);
  modport slave  (input sol_valid, input sol_data, output sol_ready);
endinterface

// File: rtl/constraint_sample_gen.sv
// constraint_sample_gen: sequential harness around a combinational constraint
// checker. It drives pseudo-random candidates (one 32-bit Galois LFSR lane per
// 32 bits of candidate) into the checker, samples the checker's satisfied
// flag in the same cycle, and collects satisfying candidates in a small FIFO
// until the requested number of solutions has been gathered.
//
// Optional feature: define SAMPLER_TIMEOUT_EN to end a run after MAX_TRIES
// evaluated candidates even when the target was not reached (timeout_o = 1).
// Without the macro a run ends only on the target and timeout_o stays 0.
module constraint_sample_gen #(
  parameter int VEC_W     = 64,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_TRIES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_load_i,
  input  logic [31:0]             seed_in_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        target_i,
  output logic [VEC_W-1:0]        cand_o,
  input  logic                    check_in_i,
  constraint_sample_gen_if.master sol_if,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [CNT_W-1:0]        tries_o,
  output logic [CNT_W-1:0]        accepted_o
);

  localparam int          LANES     = VEC_W / 32;
  localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] LANE_MIX  = 32'h9E37_79B9;
  localparam logic [31:0] RST_SEED  = 32'h0000_0001;

  // Reject parameter sets the datapath cannot represent.
  if ((VEC_W < 32) || (VEC_W % 32 != 0)) begin : gBadVecW
    $error("constraint_sample_gen: VEC_W must be a nonzero multiple of 32");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
    $error("constraint_sample_gen: DEPTH must be a power of two >= 2");
  end
  if (MAX_TRIES < 1) begin : gBadMaxTries
    $error("constraint_sample_gen: MAX_TRIES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each lane gets a decorrelated seed; the all-zero LFSR state is a lock-up
  // state, so it is replaced by 1.
  function automatic logic [31:0] laneSeed(input logic [31:0] seed, input int idx);
    logic [31:0] mixed;
    mixed = seed ^ (32'(idx) * LANE_MIX);
    return (mixed == 32'd0) ? 32'd1 : mixed;
  endfunction

  // Right-shifting Galois LFSR step.
  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] tries_q, tries_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic [31:0]      lane_q [LANES];
  logic [31:0]      lane_d [LANES];
`ifdef SAMPLER_TIMEOUT_EN
  logic             timeout_q, timeout_d;
`endif

  logic [VEC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             fifoFull;
  logic             push;
  logic             pop;

  assign fifoFull = (count_q == (PTR_W + 1)'(DEPTH));
  assign pop      = sol_if.sol_valid & sol_if.sol_ready;

  // Next-state, counter and lane update; a step evaluates one candidate.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    tries_d    = tries_q;
    accepted_d = accepted_q;
    lane_d     = lane_q;
    push       = 1'b0;
`ifdef SAMPLER_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (seed_load_i) begin
          for (int i = 0; i < LANES; i++) begin
            lane_d[i] = laneSeed(seed_in_i, i);
          end
        end else if (start_i) begin
          state_d    = RUN;
          target_d   = target_i;
          tries_d    = '0;
          accepted_d = '0;
`ifdef SAMPLER_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end
      RUN: begin
        if (accepted_q == target_q) begin
          // Only reachable with a zero target: finish without evaluating.
          state_d = DONE;
        end else if (!fifoFull) begin
          push    = check_in_i;
          tries_d = satInc(tries_q);
          if (check_in_i) begin
            accepted_d = satInc(accepted_q);
          end
          for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lfsrNext(lane_q[i]);
          end
          if (accepted_d == target_q) begin
            state_d = DONE;
          end
`ifdef SAMPLER_TIMEOUT_EN
          else if (tries_d == CNT_W'(MAX_TRIES)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      tries_q    <= '0;
      accepted_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      tries_q    <= tries_d;
      accepted_q <= accepted_d;
    end
  end

`ifdef SAMPLER_TIMEOUT_EN
  // Sticky flag telling whether the last run ended on the attempt limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // LFSR lanes that form the candidate vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= laneSeed(RST_SEED, i);
      end
    end else begin
      lane_q <= lane_d;
    end
  end

  // Solution FIFO storage and pointers; a full FIFO never accepts a push,
  // even when the head is popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= cand_o;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Pack the lanes into the candidate vector, lane 0 in the low bits.
  always_comb begin
    cand_o = '0;
    for (int i = 0; i < LANES; i++) begin
      cand_o[i*32 +: 32] = lane_q[i];
    end
  end

  assign sol_if.sol_valid = (count_q != '0);
  assign sol_if.sol_data  = mem_q[rdPtr_q];
  assign busy_o           = (state_q == RUN);
  assign done_o           = (state_q == DONE);
  assign tries_o          = tries_q;
  assign accepted_o       = accepted_q;

endmodule

// File: doc/constraint_sample_gen.md
# constraint_sample_gen

Candidate-generation and collection stage that sits directly upstream of a generated constraint checker. It drives a packed pseudo-random candidate vector into the checker's variable inputs and samples the checker's single satisfied flag (`x`) in the same cycle. Every satisfying candidate is pushed into a small output FIFO, and the stage stops when a target number of solutions has been collected. It is the sequential harness that turns a combinational constraint checker into a solution sampler.

## Interface

Parameters:
- `VEC_W`, default 64: packed candidate width. Must be a multiple of 32. The checker's variables are concatenated into this vector.
- `DEPTH`, default 4: solution FIFO depth. Must be a power of two, ≥ 2.
- `CNT_W`, default 16: width of the target, try and accept counters.
- `MAX_TRIES`, default 1000: attempt limit. Only used with `SAMPLER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `seed_load`  in  1  loads `seed_in` into the LFSR lanes. Honoured in IDLE/DONE only.
- `seed_in`  in  32  seed value.
- `start`  in  1  starts a run from IDLE or DONE.
- `target`  in  CNT_W  number of solutions wanted. Sampled on `start`.
- `cand`  out  VEC_W  candidate vector to the checker, registered.
- `check_in`  in  1  checker result for the current `cand`.
- `sol_valid`  out  1  FIFO head valid.
- `sol_ready`  in  1  consumer accepts the FIFO head.
- `sol_data`  out  VEC_W  FIFO head.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `timeout`  out  1  run ended on the attempt limit.
- `tries`  out  CNT_W  candidates evaluated in the current run.
- `accepted`  out  CNT_W  solutions pushed in the current run.

## Operation

- **Candidate generator**
  - `cand` is made of `VEC_W/32` lanes.
  - Lane i is a right-shifting Galois LFSR with mask `32'h80200003`: `next = (s>>1) ^ (s[0] ? mask : 0)`.
  - Lane i is seeded with `seed ^ (i * 32'h9E3779B9)` (32-bit product). A lane seed of 0 is replaced by 1.
  - The reset seed is `32'h0000_0001`.
- **States**
  - IDLE, RUN and DONE; reset enters IDLE.
  - IDLE → RUN on `start`. This latches `target` and clears `tries`, `accepted` and `timeout`.
  - DONE → RUN on `start`, with the same clears.
  - `start` during RUN is ignored.
- **Evaluation step (RUN only)**
  - A step occurs in every RUN cycle where the FIFO is not full.
  - If `check_in` = 1, `cand` is pushed and `accepted` increments.
  - `tries` increments and all lanes advance.
  - When the FIFO is full, the step stalls: `cand` is held and no counters change. A same-cycle pop does not unblock the push.
- **Exit conditions**
  - RUN → DONE on the edge where `accepted` reaches `target`.
  - With `target` = 0, the block goes RUN → DONE on the first RUN cycle with no evaluation.
- **FIFO**
  - Standard valid/ready output. A pop happens when `sol_valid & sol_ready`.
  - Popping continues in DONE and IDLE; the FIFO is not flushed by `start`.
- **Counters** saturate at all-ones.
- **`seed_load`**
  - Reloads the lanes in IDLE/DONE, and takes priority over `start` in the same cycle.
  - It is ignored in RUN.

## Timing

- **Reset values:** `cand` = lane seeds of `32'h1`; `sol_valid`=0; `sol_data`=0; `busy`=0; `done`=0; `timeout`=0; `tries`=0; `accepted`=0. The FIFO is empty.
- **Checker path:**
  - `check_in` is combinational from `cand` and is sampled at the same edge the lanes advance.
  - Evaluation is one candidate per cycle.
- **Push to output latency:** `sol_valid` rises one cycle after the push edge.
- **Reset mid-run:** all state returns immediately to reset values and FIFO contents are lost.

## Configuration

- `SAMPLER_TIMEOUT_EN` defined:
  - RUN → DONE with `timeout`=1 on the edge where `tries` reaches `MAX_TRIES` without `accepted` reaching `target`.
  - If both conditions hit on the same edge, `timeout`=0.
- `SAMPLER_TIMEOUT_EN` undefined:
  - No attempt limit; RUN ends only on `target`.
  - `timeout` is tied to 0.

## Test plan

- **LFSR step:** reset with `VEC_W`=64 → `cand` = {`32'h9E3779B8`, `32'h00000001`}. Then `start` with `target`=1 and `check_in`=1 → `sol_data` = {`32'h9E3779B8`, `32'h00000001`} and lane 0 = `32'h80200003`.
- **Always satisfied:** `check_in`=1, `sol_ready`=1, `target`=3 → 3 pushes on 3 consecutive edges, `tries`=3, `accepted`=3, `done`=1 the cycle after the 3rd push.
- **Backpressure:** `DEPTH`=4, `sol_ready`=0, `check_in`=1, `target`=8 → stall after 4 pushes with `tries`=4 and `cand` frozen. Raising `sol_ready` resumes; `done` follows `accepted`=8.
- **Timeout:** with the macro, `MAX_TRIES`=10, `check_in`=0, `target`=1 → `done`=1, `timeout`=1, `tries`=10. Without the macro → still `busy` after 100 cycles.
- **Control corner cases:**
  - `target`=0 → `done` two cycles after `start`, `tries`=0.
  - `seed_load` with `start` in IDLE → reseed only, state stays IDLE.
- **Reset mid-run:** assert `rst` while `busy` with a non-empty FIFO → `sol_valid`=0 and counters = 0 asynchronously.
